// File: rtl/iurt_wb_initiator.sv
// Wishbone classic initiator for a polled byte-UART responder: forwards upstream bytes,
// polls status, delivers received bytes downstream and aborts cycles that never see ack_i.
module iurt_wb_initiator #(
    parameter int POLL_INTERVAL = 4,
    parameter int ACK_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [2:2]  adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    input  logic        cfg_valid,
    input  logic        cfg_break_en,
    output logic        cfg_ready,
    output logic        err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CFG      = 3'd1;
    localparam logic [2:0] WRITE    = 3'd2;
    localparam logic [2:0] READ     = 3'd3;
    localparam logic [2:0] WAIT_GAP = 3'd4;

    localparam logic [7:0] POLL_MAX = 8'(POLL_INTERVAL);
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  poll_q, poll_d, poll_inc;
    logic [7:0]  tmo_q, tmo_d;
    logic        txk_q, txk_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic        adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        in_ready_q, in_ready_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        err_q, err_d;
    logic        unused_dat;

    assign unused_dat = ^dat_i[31:10];
    assign poll_inc   = (poll_q == POLL_MAX) ? poll_q : poll_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        poll_d      = 8'd0;
        tmo_d       = tmo_q;
        txk_d       = txk_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        in_ready_d  = 1'b0;
        cfg_ready_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_d       = err_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                poll_d = poll_inc;
                if (cfg_valid) begin
                    state_d     = CFG;
                    cyc_d       = 1'b1;
                    we_d        = 1'b1;
                    adr_d       = 1'b1;
                    dat_d       = {31'b0, cfg_break_en};
                    cfg_ready_d = 1'b1;
                    poll_d      = 8'd0;
                    tmo_d       = 8'd0;
                end else if (in_valid && txk_q) begin
                    state_d    = WRITE;
                    cyc_d      = 1'b1;
                    we_d       = 1'b1;
                    adr_d      = 1'b0;
                    dat_d      = {24'b0, in_data};
                    in_ready_d = 1'b1;
                    poll_d     = 8'd0;
                    tmo_d      = 8'd0;
                end else if (poll_inc == POLL_MAX) begin
                    // A held byte is only peeked, so it can never be overwritten by a new one.
                    state_d = READ;
                    cyc_d   = 1'b1;
                    we_d    = 1'b0;
                    adr_d   = out_valid_q;
                    dat_d   = 32'd0;
                    poll_d  = 8'd0;
                    tmo_d   = 8'd0;
                end
            end
            CFG, WRITE, READ: begin
                if (ack_i && cyc_q) begin
                    state_d = WAIT_GAP;
                    cyc_d   = 1'b0;
                    tmo_d   = 8'd0;
                    if (state_q == READ) begin
                        txk_d = dat_i[9];
                        if (!adr_q && dat_i[8]) begin
                            out_valid_d = 1'b1;
                            out_data_d  = dat_i[7:0];
                        end
                    end else if (state_q == WRITE) begin
                        txk_d = 1'b0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = WAIT_GAP;
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    tmo_d   = 8'd0;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            WAIT_GAP: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            poll_q      <= 8'd0;
            tmo_q       <= 8'd0;
            txk_q       <= 1'b0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 1'b0;
            dat_q       <= 32'd0;
            in_ready_q  <= 1'b0;
            cfg_ready_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            err_q       <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            poll_q      <= poll_d;
            tmo_q       <= tmo_d;
            txk_q       <= txk_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            in_ready_q  <= in_ready_d;
            cfg_ready_q <= cfg_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_q       <= err_d;
        end
    end

    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign we_o      = we_q;
    assign adr_o     = adr_q;
    assign dat_o     = dat_q;
    assign in_ready  = in_ready_q;
    assign cfg_ready = cfg_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_iurt_wb_initiator.sv
// Bench for iurt_wb_initiator: directed scenarios then random transactions against a
// transaction-level model of the initiator's visible behaviour.
module tb_iurt_wb_initiator;

    localparam int ACK_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst, ce;
    logic        cyc_o, stb_o, we_o;
    logic [2:2]  adr_o;
    logic [31:0] dat_o, dat_i;
    logic        ack_i;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_data, out_data;
    logic        cfg_valid, cfg_break_en, cfg_ready, err;

    int tests = 0;
    int fails = 0;

    bit       m_txk, m_ov, m_err;
    logic [7:0] m_od;

    iurt_wb_initiator #(.POLL_INTERVAL(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cfg_valid(cfg_valid), .cfg_break_en(cfg_break_en), .cfg_ready(cfg_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_launch(input int exp_edges);
        int n;
        n = 0;
        while (!cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("launch_edges", n, exp_edges);
    endtask

    // Predict the next transaction from the arbitration rules, then act as the responder.
    task automatic run_txn(input int dly, input logic [31:0] rdata, input bit tmo);
        int kind;
        int n;
        logic e_we, e_adr, e_in, e_cfg;
        logic [31:0] e_dat;
        kind  = cfg_valid ? 1 : ((in_valid && m_txk) ? 2 : 3);
        e_we  = (kind != 3);
        e_adr = (kind == 1) ? 1'b1 : ((kind == 2) ? 1'b0 : m_ov);
        e_dat = (kind == 1) ? {31'b0, cfg_break_en} : {24'b0, in_data};
        e_in  = (kind == 2);
        e_cfg = (kind == 1);
        n = 0;
        while (!cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("launch", {cyc_o, stb_o}, 2'b11);
        chk("we_adr", {we_o, adr_o}, {e_we, e_adr});
        if (kind != 3) chk("wdat", dat_o, e_dat);
        chk("ready_pulse", {in_ready, cfg_ready}, {e_in, e_cfg});
        if (kind == 1) cfg_valid = 1'b0;
        if (kind == 2) in_valid = 1'b0;
        if (tmo) begin
            n = 1;
            while (cyc_o && n < 300) begin
                tick();
                if (cyc_o) n++;
            end
            chk("tmo_len", n, ACK_TIMEOUT);
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < dly; i++) begin
                tick();
                chk("hold", {cyc_o, stb_o, we_o, adr_o, in_ready, cfg_ready},
                    {2'b11, e_we, e_adr, 2'b00});
                if (kind != 3) chk("hold_dat", dat_o, e_dat);
            end
            ack_i = 1'b1;
            dat_i = rdata;
            tick();
            ack_i = 1'b0;
            dat_i = $urandom;
            if (kind == 3) begin
                m_txk = rdata[9];
                if (!e_adr && rdata[8]) begin
                    m_ov = 1'b1;
                    m_od = rdata[7:0];
                end
            end else if (kind == 2) begin
                m_txk = 1'b0;
            end
        end
        chk("end_cyc", {cyc_o, stb_o, in_ready, cfg_ready}, 4'b0000);
        chk("err", err, m_err);
        chk("out_valid", out_valid, m_ov);
        if (m_ov) chk("out_data", out_data, m_od);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        m_ov = 1'b0;
        chk("ov_clear", out_valid, 1'b0);
    endtask

    initial begin
        int n;
        bit tmo;
        rst = 1'b1; ce = 1'b1; ack_i = 1'b0; dat_i = 32'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        cfg_valid = 1'b0; cfg_break_en = 1'b0;
        m_txk = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_od = 8'd0;

        // Reset state, asserted between clock edges.
        #3 rst = 1'b0;
        #1;
        chk("rst_bus", {cyc_o, stb_o, we_o, adr_o}, 4'b0000);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_flags", {in_ready, cfg_ready, out_valid, err}, 4'b0000);
        chk("rst_odata", {24'b0, out_data}, 32'd0);
        tick();
        tick();
        chk("rst_held", {cyc_o, out_valid, err}, 3'b000);
        rst = 1'b1;

        // First poll after release, status with tx_ready only.
        count_launch(4);
        run_txn(0, 32'h200, 1'b0);

        // Byte received, then non-consuming polls until downstream takes it.
        run_txn(1, 32'h1A5, 1'b0);
        run_txn(2, 32'h3FF, 1'b0);
        consume();

        // Forward a tx byte; the next transaction must be a poll.
        in_valid = 1'b1; in_data = 8'h3C;
        run_txn(0, 32'h0, 1'b0);
        in_valid = 1'b1; in_data = 8'h55;
        run_txn(0, 32'h200, 1'b0);

        // Write stalls to timeout; a later poll is unaffected.
        run_txn(0, 32'h0, 1'b1);
        run_txn(0, 32'h000, 1'b0);

        // A stray ack with no cycle open has no effect.
        ack_i = 1'b1; dat_i = 32'h3FF;
        tick();
        tick();
        ack_i = 1'b0;
        chk("stray_ack", {cyc_o, out_valid}, 2'b00);

        // Config beats a ready write in the same cycle.
        run_txn(0, 32'h200, 1'b0);
        cfg_valid = 1'b1; cfg_break_en = 1'b0; in_valid = 1'b1; in_data = 8'h81;
        run_txn(1, 32'h0, 1'b0);
        run_txn(0, 32'h0, 1'b0);

        // Clock enable low freezes an open cycle well past the timeout.
        n = 0;
        while (!cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("ce_launch", cyc_o, 1'b1);
        ce = 1'b0;
        repeat (300) tick();
        chk("ce_hold", {cyc_o, stb_o, we_o, adr_o, err}, {2'b11, 1'b0, m_ov, m_err});
        ce = 1'b1;
        run_txn(0, 32'h200, 1'b0);

        // Reset during an acked read: no side effect survives.
        n = 0;
        while (!cyc_o && n < 20) begin
            tick();
            n++;
        end
        chk("rst_mid_launch", cyc_o, 1'b1);
        ack_i = 1'b1; dat_i = 32'h3A5;
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_bus", {cyc_o, stb_o, we_o, adr_o}, 4'b0000);
        chk("rst_mid_flags", {in_ready, cfg_ready, out_valid, err}, 4'b0000);
        chk("rst_mid_dat", dat_o, 32'd0);
        ack_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        m_txk = 1'b0; m_ov = 1'b0; m_err = 1'b0;
        count_launch(4);
        run_txn(1, 32'h200, 1'b0);

        // Randomized traffic against the model.
        for (int it = 0; it < 40; it++) begin
            if (m_ov && ($urandom_range(1) == 1)) consume();
            if (!cfg_valid && ($urandom_range(3) == 0)) begin
                cfg_valid = 1'b1;
                cfg_break_en = 1'($urandom_range(1));
            end
            if (!in_valid && ($urandom_range(1) == 1)) begin
                in_valid = 1'b1;
                in_data = 8'($urandom);
            end
            tmo = ($urandom_range(11) == 0);
            run_txn(int'($urandom_range(3)), $urandom & 32'h3FF, tmo);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iurt_wb_initiator.md
IURT_WB_INITIATOR -- requirements
Module: iurt_wb_initiator

Interface
REQ-001 SHALL have parameter POLL_INTERVAL, default 4, meaning idle cycles between status polls (range 1..255).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 255, meaning maximum cycles waited for ack_i before abort (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ce, input, 1 bit: clock enable; when low, all state and outputs hold.
REQ-006 SHALL have Wishbone classic master ports: cyc_o, stb_o, we_o (output, 1); adr_o (output, [2:2]); dat_o (output, 32); dat_i (input, 32); ack_i (input, 1).
REQ-007 SHALL have an upstream byte sink: in_valid (input, 1), in_data (input, 8), in_ready (output, 1).
REQ-008 SHALL have a downstream byte source: out_valid (output, 1), out_data (output, 8), out_ready (input, 1).
REQ-009 SHALL have a break config port: cfg_valid (input, 1), cfg_break_en (input, 1), cfg_ready (output, 1).
REQ-010 SHALL have port err, output, 1 bit: sticky ack-timeout flag.

Function
REQ-011 Responder map SHALL be as follows.
- adr 0 read: {22'b0, tx_ready[9], rx_valid[8], rx_data[7:0]}; consumes the rx byte.
- adr 1 read: same status word, non-consuming.
- adr 0 write: dat[7:0] is a tx byte; ack is withheld while the responder buffer is full.
- adr 1 write: dat[0] is break enable.
REQ-012 FSM states SHALL be IDLE, CFG, WRITE, READ, WAIT_GAP; transactions SHALL issue only from IDLE.
REQ-013 IDLE arbitration priority SHALL be:
- CFG when cfg_valid;
- else WRITE when in_valid and tx_ready_known=1;
- else READ when poll counter reaches POLL_INTERVAL.
REQ-014 The poll counter SHALL increment each ce cycle in IDLE, saturate at POLL_INTERVAL, and clear on leaving IDLE.
REQ-015 READ SHALL use adr_o=0 when out_valid=0, else adr_o=1, so that an unconsumed byte is never overwritten.
REQ-016 On entering any transaction state, cyc_o and stb_o SHALL rise together and SHALL hold, with adr_o/we_o/dat_o stable, until ack_i or timeout.
REQ-017 On the ack_i cycle:
- cyc_o and stb_o SHALL drop on the next edge;
- FSM SHALL go to WAIT_GAP for one cycle, then IDLE.
REQ-018 WRITE entry SHALL:
- pulse in_ready for exactly one cycle;
- latch dat_o = {24'b0, in_data};
- drive we_o=1, adr_o=0.
REQ-019 CFG entry SHALL:
- pulse cfg_ready for one cycle;
- drive dat_o = {31'b0, cfg_break_en}, we_o=1, adr_o=1.
REQ-020 On a READ ack, tx_ready_known SHALL be set to dat_i[9].
REQ-021 On a READ ack with adr_o=0 and dat_i[8]=1, the block SHALL set out_data=dat_i[7:0] and out_valid=1 on the following edge.
REQ-022 A WRITE ack SHALL clear tx_ready_known to 0, forcing a poll before the next write.
REQ-023 out_valid SHALL clear on out_valid&out_ready; out_data SHALL hold while out_valid=1.
REQ-024 Ack timeout SHALL operate as follows.
- A cycle counter SHALL run while cyc_o=1.
- When it reaches ACK_TIMEOUT without ack_i, cyc_o and stb_o SHALL drop, err SHALL set, and FSM SHALL go to WAIT_GAP.
- A timed-out write byte SHALL be discarded; a timed-out read SHALL leave status unchanged.
REQ-025 ack_i SHALL be ignored while cyc_o=0.
REQ-026 err SHALL be cleared only by reset.
REQ-027 Simultaneous out_ready and READ ack with new data SHALL not occur, because adr_o=1 whenever out_valid=1.

Reset
REQ-028 Asserting rst low SHALL immediately force the following, independent of clk and ce:
- cyc_o=0, stb_o=0, we_o=0, adr_o=0, dat_o=0;
- in_ready=0, cfg_ready=0, out_valid=0, out_data=0, err=0;
- FSM=IDLE, poll counter=0, timeout counter=0, tx_ready_known=0.
REQ-029 Reset asserted mid-transaction SHALL abandon it without completing any side effect.

Verification
REQ-030 Reset release, POLL_INTERVAL=4, ack after 1 cycle with dat_i=0x200 -> read at adr 0 starts 4 cycles after release; tx_ready_known=1; out_valid stays 0.
REQ-031 Read at adr 0 returns 0x1A5 -> out_valid=1, out_data=0xA5; subsequent polls use adr 1 until out_ready handshake.
REQ-032 tx_ready_known=1, in_valid=1, in_data=0x3C -> in_ready one-cycle pulse; write adr 0 with dat_o=0x0000003C; next transaction is a poll.
REQ-033 Write held without ack for 255 cycles -> cyc_o drops on the 255th, err=1; a later poll proceeds normally.
REQ-034 cfg_valid=1, cfg_break_en=0 and in_valid=1 in the same IDLE cycle -> CFG first (write adr 1, dat_o=0), then WRITE after gap.
REQ-035 rst low while cyc_o=1, or ce low mid-transaction -> reset: all outputs 0 immediately; ce low: cyc_o, counters, and state frozen.
